usb_audio_in_packer: RTL
========================

Name: usb_audio_in_packer

Overview:
- Capture side of the USB Audio class: the device-to-host (microphone) counterpart of the audio playback path.
- Accepts 48 kHz 16-bit stereo samples from an ADC interface and buffers them in a circular FIFO.
- On each USB start-of-frame it streams one isochronous packet of little-endian PCM bytes into the usbfs core IN byte interface (in_data/in_valid/in_ready).

Parameters:
- FIFO_AW, 7: log2 of FIFO depth in stereo frames; depth = 2**FIFO_AW = 128 frames, 32 bits each.
- PKT_FRAMES, 48: maximum stereo frames per USB packet. 48 frames = 1 ms at 48 kHz = 192 bytes. Must be less than 2**FIFO_AW.

Ports:
- clk  input  1  system clock, 60 MHz.
- usb_rstn  input  1  reset from usbfs core; asynchronous, active-low.
- sof  input  1  one-cycle pulse per USB frame (1 kHz) from usbfs core.
- sample_valid  input  1  one-cycle strobe; audio_L_ch/audio_R_ch hold a new frame.
- audio_L_ch  input  16  left sample from ADC.
- audio_R_ch  input  16  right sample from ADC.
- in_data  output  8  byte to usbfs core IN endpoint.
- in_valid  output  1  in_data is valid.
- in_ready  input  1  core accepts a byte when in_valid and in_ready are both high.
- fifo_level  output  FIFO_AW+1  stored stereo frames, 0..2**FIFO_AW.
- overflow  output  1  sticky; a sample was dropped because the FIFO was full.
- underrun  output  1  sticky; sof arrived while fifo_level was 0.

Behaviour:
- Reset (usb_rstn=0, asynchronous):
  - in_data=0, in_valid=0, fifo_level=0, overflow=0, underrun=0.
  - FIFO pointers cleared; state=IDLE.
  - Reset mid-packet drops in_valid immediately and discards the packet and all FIFO contents.
- Write side:
  - On sample_valid with FIFO not full, store {R,L} (after optional conversion) at wr_ptr and increment wr_ptr.
  - Pointers are FIFO_AW bits wide and wrap modulo depth.
  - On sample_valid with FIFO full: drop the sample, set overflow; existing data is untouched.
- Level:
  - fifo_level is registered.
  - +1 on an accepted write with no pop.
  - -1 on a pop with no write.
  - Unchanged when a write and a pop occur in the same cycle.
  - A pop happens when the final byte of a frame (R high byte) is accepted.
- FSM states: IDLE, SEND.
  - IDLE: on sof, snapshot n = min(fifo_level, PKT_FRAMES) into frames_left.
    - n=0: set underrun, stay in IDLE, emit nothing.
    - n>0: go to SEND with byte_idx=0.
  - SEND: in_valid=1.
    - Byte order per frame: byte_idx 0=L[7:0], 1=L[15:8], 2=R[7:0], 3=R[15:8].
    - Each accepted byte advances byte_idx (2 bits, wraps).
    - After byte 3 is accepted: pop the frame and decrement frames_left.
    - When frames_left reaches 0: go to IDLE. in_valid is low on the cycle after the last handshake.
  - sof while in SEND is ignored; the current packet continues and no new snapshot is taken.
- Timing and handshake:
  - Latency: sof at cycle N gives in_valid=1 and the first byte on in_data at cycle N+1 or N+2. This is fixed by the implementation's FIFO read latency and must be documented in the RTL header.
  - in_data and in_valid are registered outputs.
  - While in_valid=1 and in_ready=0, in_data holds stable.
  - Back-to-back acceptance at one byte per cycle must be sustained.
- Packet length: total bytes = 4*n, always a whole number of stereo frames; partial frames are never sent.
- Arithmetic: fifo_level never exceeds 2**FIFO_AW. Full when fifo_level==2**FIFO_AW; empty when 0.

Optional Feature:
- Macro: AUDIO_IN_OFFSET_BINARY_EN.
- Defined: ADC samples are treated as unsigned offset-binary. The MSB of each channel is inverted before storage (0x8000 becomes 0x0000, 0x0000 becomes 0x8000), producing USB two's-complement PCM.
- Undefined: samples are stored and sent unmodified (ADC already two's-complement).

Test Plan:
- Write 48 frames L=0x1100+i, R=0x2200+i, then pulse sof with in_ready=1:
  - Expect exactly 192 bytes: 00 11 00 22 01 11 01 22 ...
  - Expect in_valid low after the 192nd byte and fifo_level=0.
- Write 10 frames, then sof: expect 40 bytes, fifo_level 10→0, underrun=0.
- sof with an empty FIFO: expect no in_valid and underrun=1 (sticky until reset).
- Write 130 frames without sof: expect fifo_level=128 and overflow=1. A subsequent sof outputs frames 0..47 only (frames 128 and 129 were dropped).
- Toggle in_ready randomly during a 48-frame packet with sample_valid firing concurrently:
  - in_data stays stable while stalled.
  - Byte stream matches the model.
  - A second sof mid-packet is ignored.
  - fifo_level stays consistent under simultaneous push/pop.
- Assert usb_rstn low mid-packet: in_valid drops at once. After release, fifo_level=0 and the flags are cleared. With AUDIO_IN_OFFSET_BINARY_EN defined, input L=0x0000 is sent as bytes 00 80.

Source files
------------

// File: rtl/usb_audio_in_packer.sv
// rtl/usb_audio_in_packer.sv - USB audio IN packer: 48 kHz stereo FIFO, one isochronous packet per sof.
// sof sampled at edge N -> in_valid and first byte registered at that edge (visible cycle N+1). Macro: AUDIO_IN_OFFSET_BINARY_EN.
module usb_audio_in_packer #(
  parameter int FIFO_AW    = 7,
  parameter int PKT_FRAMES = 48
) (
  input  logic               clk,
  input  logic               usb_rstn,
  input  logic               sof,
  input  logic               sample_valid,
  input  logic [15:0]        audio_L_ch,
  input  logic [15:0]        audio_R_ch,
  output logic [7:0]         in_data,
  output logic               in_valid,
  input  logic               in_ready,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               overflow,
  output logic               underrun
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_L = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0] PKT_L   = (FIFO_AW+1)'(PKT_FRAMES);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [31:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   level_q, level_d, frames_left_q, frames_left_d;
  logic [1:0]         byte_idx_q, byte_idx_d;
  logic [0:0]         state_q, state_d;
  logic [7:0]         data_q, data_d;
  logic               valid_q, valid_d, ovf_q, ovf_d, und_q, und_d;
  logic               full, push, hs, pop;
  logic [31:0]        wdata;

`ifdef AUDIO_IN_OFFSET_BINARY_EN
  assign wdata = {audio_R_ch ^ 16'h8000, audio_L_ch ^ 16'h8000};
`else
  assign wdata = {audio_R_ch, audio_L_ch};
`endif

  assign full = (level_q == DEPTH_L);
  assign push = sample_valid && !full;
  assign hs   = valid_q && in_ready;
  assign pop  = hs && (byte_idx_q == 2'd3);

  function automatic logic [7:0] pick(input logic [31:0] f, input logic [1:0] idx);
    case (idx)
      2'd0:    pick = f[7:0];
      2'd1:    pick = f[15:8];
      2'd2:    pick = f[23:16];
      default: pick = f[31:24];
    endcase
  endfunction

  always_comb begin
    wr_ptr_d      = wr_ptr_q + FIFO_AW'(push);
    rd_ptr_d      = rd_ptr_q;
    level_d       = level_q + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
    frames_left_d = frames_left_q;
    byte_idx_d    = byte_idx_q;
    state_d       = state_q;
    data_d        = data_q;
    valid_d       = valid_q;
    ovf_d         = ovf_q | (sample_valid & full);
    und_d         = und_q;
    if (state_q == S_IDLE) begin
      if (sof) begin
        if (level_q == '0) begin
          und_d = 1'b1;
        end else begin
          frames_left_d = (level_q < PKT_L) ? level_q : PKT_L;
          byte_idx_d    = 2'd0;
          state_d       = S_SEND;
          valid_d       = 1'b1;
          data_d        = mem[rd_ptr_q][7:0];
        end
      end
    end else if (hs) begin
      if (byte_idx_q == 2'd3) begin
        rd_ptr_d      = rd_ptr_q + 1'b1;
        frames_left_d = frames_left_q - 1'b1;
        byte_idx_d    = 2'd0;
        if (frames_left_q == (FIFO_AW+1)'(1)) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
          data_d  = 8'h00;
        end else begin
          // Next frame is guaranteed stored: it was counted in the sof snapshot.
          data_d = mem[rd_ptr_d][7:0];
        end
      end else begin
        byte_idx_d = byte_idx_q + 1'b1;
        data_d     = pick(mem[rd_ptr_q], byte_idx_d);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge usb_rstn) begin
    if (!usb_rstn) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      frames_left_q <= '0;
      byte_idx_q    <= 2'd0;
      state_q       <= S_IDLE;
      data_q        <= 8'h00;
      valid_q       <= 1'b0;
      ovf_q         <= 1'b0;
      und_q         <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      frames_left_q <= frames_left_d;
      byte_idx_q    <= byte_idx_d;
      state_q       <= state_d;
      data_q        <= data_d;
      valid_q       <= valid_d;
      ovf_q         <= ovf_d;
      und_q         <= und_d;
    end
  end

  assign in_data    = data_q;
  assign in_valid   = valid_q;
  assign fifo_level = level_q;
  assign overflow   = ovf_q;
  assign underrun   = und_q;

endmodule
